// File: rtl/noc_pkg.sv
// Shared flit layout, FSM encoding and sizing constants for the NoC injection path.
package noc_pkg;
  localparam int FLIT_W  = 22;
  localparam int VALID   = 21;
  localparam int VC_HI   = 20;
  localparam int VC_LO   = 16;
  localparam int HEAD    = 15;
  localparam int TAIL    = 14;
  localparam int PAY_HI  = 13;
  localparam int VC_W    = VC_HI - VC_LO + 1;
  localparam int MAXIO   = 32;  // largest VC count addressable by a 5-bit VC id
  localparam int CRBUFSZ = 4;   // default downstream slots per VC

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALLOC = 2'd1,
    ST_SEND  = 2'd2
  } state_e;
endpackage

// File: rtl/credit_counter_bank.sv
// Per-VC saturating credit counters; reports which VCs hold credit and flags bad returns.
module credit_counter_bank
  import noc_pkg::*;
#(
  parameter int NUM_VCS = 4,
  parameter int DEPTH   = CRBUFSZ,
  parameter int CW      = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc_i,
  input  logic [VC_W-1:0]    inc_vc_i,
  input  logic               dec_i,
  input  logic [VC_W-1:0]    dec_vc_i,
  output logic [NUM_VCS-1:0] nz_o,
  output logic               ovf_o
);
  localparam logic [VC_W:0] NVC = (VC_W + 1)'(NUM_VCS);

  logic [NUM_VCS-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NUM_VCS-1:0]         inc_v, dec_v, sat_v;
  logic                       bad_vc;

  // A simultaneous send and return on one VC cancel, so neither saturation nor underflow applies.
  always_comb begin
    cnt_d = cnt_q;
    inc_v = '0;
    dec_v = '0;
    sat_v = '0;
    nz_o  = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      inc_v[v] = inc_i && (inc_vc_i == VC_W'(v));
      dec_v[v] = dec_i && (dec_vc_i == VC_W'(v));
      sat_v[v] = inc_v[v] && !dec_v[v] && (cnt_q[v] == CW'(DEPTH));
      nz_o[v]  = (cnt_q[v] != '0);
      if (inc_v[v] && !dec_v[v] && !sat_v[v])
        cnt_d[v] = cnt_q[v] + CW'(1);
      else if (dec_v[v] && !inc_v[v] && nz_o[v])
        cnt_d[v] = cnt_q[v] - CW'(1);
    end
  end

  assign bad_vc = inc_i && ({1'b0, inc_vc_i} >= NVC);
  assign ovf_o  = (|sat_v) || bad_vc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VCS; v++) cnt_q[v] <= CW'(DEPTH);
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/flit_injector.sv
// Host-side packet injector: round-robin VC allocation, credit-gated wormhole serialisation.
module flit_injector
  import noc_pkg::*;
#(
  parameter int NUM_VCS      = 4,
  parameter int VC_BUF_DEPTH = CRBUFSZ,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pkt_valid,
  output logic              pkt_ready,
  input  logic [13:0]       pkt_dest,
  input  logic [4:0]        pkt_len,
  input  logic              can_inject,
  input  logic [FLIT_W-1:0] credit_in,
  output logic [FLIT_W-1:0] flit_out,
  output logic              busy,
  output logic              cr_err,
  output logic [CNT_W-1:0]  flits_sent
);
  state_e            state_q, state_d;
  logic [13:0]       dest_q, dest_d;
  logic [4:0]        len_q, len_d, idx_q, idx_d;
  logic [VC_W-1:0]   vc_q, vc_d, rr_q, rr_d, pick, cand;
  logic [FLIT_W-1:0] flit_q, flit_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              rdy_q, busy_q, err_q, found, emit, is_tail, ovf;
  logic [NUM_VCS-1:0] nz;
  logic [MAXIO-1:0]  nz_w;
  logic              unused_cr;

  assign nz_w      = MAXIO'(nz);
  assign unused_cr = ^credit_in[VC_LO-1:0];

  credit_counter_bank #(.NUM_VCS(NUM_VCS), .DEPTH(VC_BUF_DEPTH)) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_i    (credit_in[VALID]),
    .inc_vc_i (credit_in[VC_HI:VC_LO]),
    .dec_i    (emit),
    .dec_vc_i (vc_q),
    .nz_o     (nz),
    .ovf_o    (ovf)
  );

  // First VC holding credit, scanning upward from the round-robin pointer.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < NUM_VCS; i++) begin
      cand = VC_W'((int'(rr_q) + i) % NUM_VCS);
      if (!found && nz_w[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    len_d   = len_q;
    idx_d   = idx_q;
    vc_d    = vc_q;
    rr_d    = rr_q;
    flit_d  = '0;
    emit    = 1'b0;
    is_tail = (idx_q == len_q - 5'd1);
    case (state_q)
      ST_IDLE: if (pkt_valid && rdy_q) begin
        dest_d  = pkt_dest;
        len_d   = (pkt_len == '0) ? 5'd1 : pkt_len;
        idx_d   = '0;
        state_d = ST_ALLOC;
      end
      ST_ALLOC: if (found) begin
        vc_d    = pick;
        rr_d    = VC_W'((int'(pick) + 1) % NUM_VCS);
        state_d = ST_SEND;
      end
      ST_SEND: if (can_inject && nz_w[vc_q]) begin
        emit                 = 1'b1;
        flit_d[VALID]        = 1'b1;
        flit_d[VC_HI:VC_LO]  = vc_q;
        flit_d[HEAD]         = (idx_q == '0);
        flit_d[TAIL]         = is_tail;
        flit_d[PAY_HI:0]     = (idx_q == '0) ? dest_q : 14'(idx_q);
        idx_d                = idx_q + 5'd1;
        if (is_tail) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dest_q  <= '0;
      len_q   <= 5'd1;
      idx_q   <= '0;
      vc_q    <= '0;
      rr_q    <= '0;
      flit_q  <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      vc_q    <= vc_d;
      rr_q    <= rr_d;
      flit_q  <= flit_d;
      cnt_q   <= cnt_q + CNT_W'(emit);
      rdy_q   <= (state_d == ST_IDLE);
      busy_q  <= (state_d != ST_IDLE);
      err_q   <= err_q | ovf;
    end
  end

  assign flit_out   = flit_q;
  assign pkt_ready  = rdy_q;
  assign busy       = busy_q;
  assign cr_err     = err_q;
  assign flits_sent = cnt_q;
endmodule

// File: tb/tb_flit_injector.sv
// Scenario bench for flit_injector with a credit/flit reference model kept in the bench.
module tb_flit_injector;
  logic        clk, rst_n, pkt_valid, pkt_ready, can_inject, busy, cr_err;
  logic [13:0] pkt_dest;
  logic [4:0]  pkt_len;
  logic [21:0] credit_in, flit_out;
  logic [15:0] flits_sent;

  typedef struct {logic [13:0] dest; logic [4:0] len;} pkt_t;

  int          total = 0, bad = 0;
  int          mcred[4];
  logic [21:0] obs[$];
  logic [4:0]  ret[$];
  pkt_t        pq[$];
  bit          last_acc;

  flit_injector dut (
    .clk(clk), .rst_n(rst_n), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_dest(pkt_dest), .pkt_len(pkt_len), .can_inject(can_inject),
    .credit_in(credit_in), .flit_out(flit_out), .busy(busy), .cr_err(cr_err),
    .flits_sent(flits_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [21:0] flit_exp(input int vc, input logic [13:0] dest,
                                           input logic [4:0] len, input int k);
    int L;
    logic [21:0] f;
    L = (len == 5'd0) ? 1 : int'(len);
    f = '0;
    f[21] = 1'b1;
    f[20:16] = vc[4:0];
    f[15] = (k == 0);
    f[14] = (k == L - 1);
    f[13:0] = (k == 0) ? dest : k[13:0];
    return f;
  endfunction

  // One clock: track credits in the model and record every emitted flit.
  task automatic tick();
    bit acc;
    logic [21:0] ci;
    int pre[4];
    int dv, nv;
    acc = pkt_valid && pkt_ready;
    ci  = credit_in;
    pre = mcred;
    @(posedge clk); #1;
    last_acc = acc;
    dv = -1;
    if (flit_out[21] === 1'b1) begin
      dv = int'(flit_out[20:16]);
      total++;
      if (dv >= 4 || pre[dv] <= 0) begin
        bad++;
        $display("FAIL no_credit_send: flit %h sent, model credit not positive", flit_out);
      end
      obs.push_back(flit_out);
      ret.push_back(flit_out[20:16]);
    end
    for (int v = 0; v < 4; v++) begin
      nv = pre[v];
      if (dv == v) nv--;
      if (ci[21] && int'(ci[20:16]) == v && !(pre[v] == 4 && dv != v)) nv++;
      mcred[v] = nv;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pkt_valid = 1'b0; can_inject = 1'b0; credit_in = '0;
    pkt_dest = '0; pkt_len = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int v = 0; v < 4; v++) mcred[v] = 4;
    obs.delete(); ret.delete(); pq.delete();
    tick();
  endtask

  task automatic run_pkts(input int budget, input int nflits, input int ci_pct, input int cr_pct);
    int n;
    n = 0;
    while (obs.size() < nflits && n < budget) begin
      pkt_valid = (pq.size() > 0);
      if (pq.size() > 0) begin pkt_dest = pq[0].dest; pkt_len = pq[0].len; end
      can_inject = ($urandom_range(99) < ci_pct);
      credit_in = '0;
      if (ret.size() > 0 && $urandom_range(99) < cr_pct) credit_in = {1'b1, ret.pop_front(), 16'h0};
      tick();
      if (last_acc) pq.delete(0);
      n++;
    end
    pkt_valid = 1'b0; can_inject = 1'b0; credit_in = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pkt_valid = 1'b1; can_inject = 1'b1; credit_in = 22'h200000;
    pkt_dest = 14'h3; pkt_len = 5'd2;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (flit_out !== '0 || pkt_ready !== 1'b0 || busy !== 1'b0 || cr_err !== 1'b0 || flits_sent !== '0) begin
      bad++;
      $display("FAIL reset_outputs: flit=%h rdy=%b busy=%b err=%b sent=%0d want all zero",
               flit_out, pkt_ready, busy, cr_err, flits_sent);
    end
    do_reset();
    total++;
    if (pkt_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", pkt_ready); end
    for (int v = 0; v < 4; v++) begin
      total++;
      if (dut.u_bank.cnt_q[v] !== 3'd4) begin
        bad++; $display("FAIL reset_credit%0d: got %0d want 4", v, dut.u_bank.cnt_q[v]);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    pkt_valid = 1'b1; pkt_dest = 14'h5; pkt_len = 5'd1; can_inject = 1'b1;
    tick();
    pkt_valid = 1'b0;
    total++;
    if (!last_acc || flit_out !== '0) begin
      bad++; $display("FAIL single_accept: acc=%b flit=%h want acc=1 flit=0", last_acc, flit_out);
    end
    tick();
    total++;
    if (flit_out !== '0) begin bad++; $display("FAIL single_alloc: got %h want 0", flit_out); end
    tick();
    total++;
    if (flit_out !== 22'h20C005) begin bad++; $display("FAIL single_flit: got %h want 20c005", flit_out); end
    total++;
    if (flits_sent !== 16'd1 || dut.u_bank.cnt_q[0] !== 3'd3 || busy !== 1'b0 || pkt_ready !== 1'b1) begin
      bad++;
      $display("FAIL single_after: sent=%0d cr0=%0d busy=%b rdy=%b want 1 3 0 1",
               flits_sent, dut.u_bank.cnt_q[0], busy, pkt_ready);
    end
  endtask

  task automatic test_credit_stall();
    do_reset();
    pkt_valid = 1'b1; pkt_dest = 14'h123; pkt_len = 5'd6; can_inject = 1'b1;
    tick();
    pkt_valid = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (flit_out !== flit_exp(0, 14'h123, 5'd6, k)) begin
        bad++; $display("FAIL stall_flit%0d: got %h want %h", k, flit_out, flit_exp(0, 14'h123, 5'd6, k));
      end
    end
    repeat (3) begin
      tick();
      total++;
      if (flit_out !== '0 || busy !== 1'b1) begin
        bad++; $display("FAIL stall_hold: flit=%h busy=%b want 0 1", flit_out, busy);
      end
    end
    credit_in = 22'h200000;
    tick();
    total++;
    if (flit_out !== '0) begin bad++; $display("FAIL stall_same_cycle_credit: got %h want 0", flit_out); end
    tick();
    credit_in = '0;
    total++;
    if (flit_out !== flit_exp(0, 14'h123, 5'd6, 4)) begin
      bad++; $display("FAIL stall_flit4: got %h want %h", flit_out, flit_exp(0, 14'h123, 5'd6, 4));
    end
    tick();
    total++;
    if (flit_out !== flit_exp(0, 14'h123, 5'd6, 5) || busy !== 1'b0 || pkt_ready !== 1'b1) begin
      bad++; $display("FAIL stall_tail: got %h busy=%b rdy=%b want %h 0 1",
                      flit_out, busy, pkt_ready, flit_exp(0, 14'h123, 5'd6, 5));
    end
    total++;
    if (flits_sent !== 16'd6 || dut.u_bank.cnt_q[0] !== 3'(mcred[0]) || mcred[0] != 0) begin
      bad++; $display("FAIL stall_counts: sent=%0d cr0=%0d want 6 0", flits_sent, dut.u_bank.cnt_q[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] d[6];
    logic [4:0]  l[6];
    int          vcs[6];
    int          j;
    do_reset();
    for (int i = 0; i < 3; i++) pq.push_back('{14'(16 * i + 17), 5'd1});
    run_pkts(100, 3, 100, 0);
    total++;
    if (obs.size() != 3) begin bad++; $display("FAIL rr_count: got %0d want 3", obs.size()); end
    for (int i = 0; i < 3 && i < obs.size(); i++) begin
      total++;
      if (obs[i] !== flit_exp(i, 14'(16 * i + 17), 5'd1, 0)) begin
        bad++; $display("FAIL rr_vc%0d: got %h want %h", i, obs[i], flit_exp(i, 14'(16 * i + 17), 5'd1, 0));
      end
    end
    // vc1 is emptied by the 4-flit packet, so the sixth packet must skip it.
    do_reset();
    vcs = '{0, 1, 2, 3, 0, 2};
    for (int i = 0; i < 6; i++) begin
      d[i] = 14'($urandom);
      l[i] = (i == 1) ? 5'd4 : 5'd1;
      pq.push_back('{d[i], l[i]});
    end
    run_pkts(300, 9, 100, 0);
    total++;
    if (obs.size() != 9) begin bad++; $display("FAIL skip_count: got %0d want 9", obs.size()); end
    j = 0;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < int'(l[i]); k++) begin
        if (j < obs.size()) begin
          total++;
          if (obs[j] !== flit_exp(vcs[i], d[i], l[i], k)) begin
            bad++; $display("FAIL skip_pkt%0d_flit%0d: got %h want %h", i, k, obs[j], flit_exp(vcs[i], d[i], l[i], k));
          end
        end
        j++;
      end
    end
    total++;
    if (dut.u_bank.cnt_q[1] !== 3'd0) begin bad++; $display("FAIL skip_cr1: got %0d want 0", dut.u_bank.cnt_q[1]); end
  endtask

  task automatic test_can_inject();
    int k;
    bit ci;
    do_reset();
    pkt_valid = 1'b1; pkt_dest = 14'h2AA; pkt_len = 5'd4; can_inject = 1'b0;
    tick();
    pkt_valid = 1'b0;
    tick();
    k = 0;
    for (int i = 0; i < 8; i++) begin
      ci = (i % 2 == 0);
      can_inject = ci;
      tick();
      total++;
      if (ci) begin
        if (flit_out !== flit_exp(0, 14'h2AA, 5'd4, k)) begin
          bad++; $display("FAIL ci_on%0d: got %h want %h", i, flit_out, flit_exp(0, 14'h2AA, 5'd4, k));
        end
        k++;
      end else if (flit_out !== '0) begin
        bad++; $display("FAIL ci_off%0d: got %h want 0", i, flit_out);
      end
    end
    can_inject = 1'b0;
    total++;
    if (busy !== 1'b0 || flits_sent !== 16'd4) begin
      bad++; $display("FAIL ci_done: busy=%b sent=%0d want 0 4", busy, flits_sent);
    end
  endtask

  task automatic test_cr_err();
    do_reset();
    total++;
    if (cr_err !== 1'b0) begin bad++; $display("FAIL crerr_init: got %b want 0", cr_err); end
    credit_in = {1'b1, 5'd3, 16'h0};
    tick();
    credit_in = '0;
    total++;
    if (cr_err !== 1'b1) begin bad++; $display("FAIL crerr_full: got %b want 1", cr_err); end
    repeat (3) tick();
    total++;
    if (cr_err !== 1'b1) begin bad++; $display("FAIL crerr_sticky: got %b want 1", cr_err); end
    for (int v = 0; v < 4; v++) begin
      total++;
      if (dut.u_bank.cnt_q[v] !== 3'd4) begin bad++; $display("FAIL crerr_cnt%0d: got %0d want 4", v, dut.u_bank.cnt_q[v]); end
    end
    do_reset();
    credit_in = {1'b1, 5'd7, 16'hFFFF};
    tick();
    credit_in = '0;
    tick();
    total++;
    if (cr_err !== 1'b1) begin bad++; $display("FAIL crerr_badvc: got %b want 1", cr_err); end
    for (int v = 0; v < 4; v++) begin
      total++;
      if (dut.u_bank.cnt_q[v] !== 3'd4) begin bad++; $display("FAIL badvc_cnt%0d: got %0d want 4", v, dut.u_bank.cnt_q[v]); end
    end
  endtask

  task automatic test_reset_mid();
    bit quiet;
    do_reset();
    pkt_valid = 1'b1; pkt_dest = 14'h77; pkt_len = 5'd5; can_inject = 1'b1;
    tick();
    pkt_valid = 1'b0;
    repeat (3) tick();
    total++;
    if (flit_out !== flit_exp(0, 14'h77, 5'd5, 1)) begin
      bad++; $display("FAIL mid_second: got %h want %h", flit_out, flit_exp(0, 14'h77, 5'd5, 1));
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (flit_out !== '0 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_async: flit=%h busy=%b want 0 0", flit_out, busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int v = 0; v < 4; v++) mcred[v] = 4;
    for (int v = 0; v < 4; v++) begin
      total++;
      if (dut.u_bank.cnt_q[v] !== 3'd4) begin bad++; $display("FAIL mid_cnt%0d: got %0d want 4", v, dut.u_bank.cnt_q[v]); end
    end
    tick();
    total++;
    if (pkt_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", pkt_ready); end
    quiet = 1'b1;
    repeat (4) begin
      tick();
      if (flit_out !== '0) quiet = 1'b0;
    end
    can_inject = 1'b0;
    total++;
    if (!quiet) begin bad++; $display("FAIL mid_no_tail: flit seen after reset, want none"); end
  endtask

  task automatic test_random();
    pkt_t pk[12];
    int   nfl, j, n;
    logic [4:0] hvc;
    do_reset();
    nfl = 0;
    for (int i = 0; i < 12; i++) begin
      pk[i].dest = 14'($urandom);
      pk[i].len  = 5'($urandom_range(0, 8));
      nfl += (pk[i].len == 5'd0) ? 1 : int'(pk[i].len);
      pq.push_back(pk[i]);
    end
    run_pkts(4000, nfl, 70, 50);
    total++;
    if (obs.size() != nfl) begin bad++; $display("FAIL rand_count: got %0d want %0d", obs.size(), nfl); end
    j = 0;
    for (int i = 0; i < 12; i++) begin
      hvc = (j < obs.size()) ? obs[j][20:16] : 5'd0;
      for (int k = 0; k < ((pk[i].len == 5'd0) ? 1 : int'(pk[i].len)); k++) begin
        if (j < obs.size()) begin
          total++;
          if (obs[j] !== flit_exp(int'(hvc), pk[i].dest, pk[i].len, k) || hvc > 5'd3) begin
            bad++; $display("FAIL rand_pkt%0d_flit%0d: got %h want %h", i, k, obs[j], flit_exp(int'(hvc), pk[i].dest, pk[i].len, k));
          end
        end
        j++;
      end
    end
    n = 0;
    while (ret.size() > 0 && n < 200) begin
      credit_in = {1'b1, ret.pop_front(), 16'h0};
      tick();
      n++;
    end
    credit_in = '0;
    tick();
    for (int v = 0; v < 4; v++) begin
      total++;
      if (dut.u_bank.cnt_q[v] !== 3'd4 || mcred[v] != 4) begin
        bad++; $display("FAIL rand_cnt%0d: got %0d model %0d want 4", v, dut.u_bank.cnt_q[v], mcred[v]);
      end
    end
    total++;
    if (flits_sent !== 16'(nfl) || cr_err !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rand_final: sent=%0d err=%b busy=%b want %0d 0 0", flits_sent, cr_err, busy, nfl);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_credit_stall();
    test_back_to_back();
    test_can_inject();
    test_cr_err();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
